// File: rtl/fpu_stack_regfile.sv
// x87-style register stack: DEPTH registers addressed relative to TOP, with tags and fault detection.
// Optional FLDENV/FRSTOR-style environment load enabled by defining FPU_STACK_ENVLOAD_EN.
module fpu_stack_regfile #(
    parameter int WIDTH = 80,
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    input  logic [2:0]           cmd,
    input  logic [PTR_W-1:0]     cmd_idx,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [1:0]           wr_tag,
    input  logic [PTR_W-1:0]     rd_idx_a,
    input  logic [PTR_W-1:0]     rd_idx_b,
`ifdef FPU_STACK_ENVLOAD_EN
    input  logic                 env_load,
    input  logic [PTR_W-1:0]     env_top,
    input  logic [2*DEPTH-1:0]   env_tags,
`endif
    input  logic                 clr_fault,
    output logic [WIDTH-1:0]     rd_data_a,
    output logic [WIDTH-1:0]     rd_data_b,
    output logic [1:0]           rd_tag_a,
    output logic [1:0]           rd_tag_b,
    output logic [PTR_W-1:0]     top,
    output logic [2*DEPTH-1:0]   tag_word,
    output logic                 stack_fault,
    output logic                 fault_c1
);

    localparam logic [2:0] CMD_NOP    = 3'd0;
    localparam logic [2:0] CMD_PUSH   = 3'd1;
    localparam logic [2:0] CMD_POP    = 3'd2;
    localparam logic [2:0] CMD_WRITE  = 3'd3;
    localparam logic [2:0] CMD_XCHG   = 3'd4;
    localparam logic [2:0] CMD_FREE   = 3'd5;
    localparam logic [2:0] CMD_INCSTP = 3'd6;
    localparam logic [2:0] CMD_DECSTP = 3'd7;
    localparam logic [1:0] TAG_EMPTY  = 2'b11;

    // The empty encoding can never be written explicitly; it degrades to "special".
    function automatic logic [1:0] legal_tag(input logic [1:0] t);
        if (t == TAG_EMPTY) begin
            return 2'b10;
        end else begin
            return t;
        end
    endfunction

    logic [WIDTH-1:0] data_r     [DEPTH];
    logic [1:0]       tag_r      [DEPTH];
    logic [PTR_W-1:0] top_r;
    logic [WIDTH-1:0] data_nxt_s [DEPTH];
    logic [1:0]       tag_nxt_s  [DEPTH];
    logic [PTR_W-1:0] top_nxt_s;
    logic             fault_s;
    logic             c1_s;
    logic [PTR_W-1:0] top_dec_s;
    logic [PTR_W-1:0] top_inc_s;
    logic [PTR_W-1:0] idx_phys_s;
    logic [PTR_W-1:0] rd_phys_a_s;
    logic [PTR_W-1:0] rd_phys_b_s;
    logic [1:0]       wr_tag_s;

    // PTR_W-bit sums wrap modulo DEPTH because DEPTH is a power of two.
    assign top_dec_s   = top_r - PTR_W'(1'b1);
    assign top_inc_s   = top_r + PTR_W'(1'b1);
    assign idx_phys_s  = top_r + cmd_idx;
    assign rd_phys_a_s = top_r + rd_idx_a;
    assign rd_phys_b_s = top_r + rd_idx_b;
    assign wr_tag_s    = legal_tag(wr_tag);
    assign top         = top_r;

    // Next-state decode of the single command accepted this cycle.
    always_comb begin
        data_nxt_s = data_r;
        tag_nxt_s  = tag_r;
        top_nxt_s  = top_r;
        fault_s    = 1'b0;
        c1_s       = 1'b0;
        if (cmd_valid) begin
            case (cmd)
                CMD_PUSH: begin
                    if (tag_r[top_dec_s] != TAG_EMPTY) begin
                        fault_s = 1'b1;
                        c1_s    = 1'b1;
                    end else begin
                        top_nxt_s             = top_dec_s;
                        data_nxt_s[top_dec_s] = wr_data;
                        tag_nxt_s[top_dec_s]  = wr_tag_s;
                    end
                end
                CMD_POP: begin
                    if (tag_r[top_r] == TAG_EMPTY) begin
                        fault_s = 1'b1;
                        c1_s    = 1'b0;
                    end else begin
                        tag_nxt_s[top_r] = TAG_EMPTY;
                        top_nxt_s        = top_inc_s;
                    end
                end
                CMD_WRITE: begin
                    data_nxt_s[idx_phys_s] = wr_data;
                    tag_nxt_s[idx_phys_s]  = wr_tag_s;
                end
                CMD_XCHG: begin
                    if ((tag_r[top_r] == TAG_EMPTY) || (tag_r[idx_phys_s] == TAG_EMPTY)) begin
                        fault_s = 1'b1;
                        c1_s    = 1'b0;
                    end else begin
                        data_nxt_s[top_r]      = data_r[idx_phys_s];
                        data_nxt_s[idx_phys_s] = data_r[top_r];
                        tag_nxt_s[top_r]       = tag_r[idx_phys_s];
                        tag_nxt_s[idx_phys_s]  = tag_r[top_r];
                    end
                end
                CMD_FREE:   tag_nxt_s[idx_phys_s] = TAG_EMPTY;
                CMD_INCSTP: top_nxt_s = top_inc_s;
                CMD_DECSTP: top_nxt_s = top_dec_s;
                CMD_NOP:    top_nxt_s = top_r;
                default:    top_nxt_s = top_r;
            endcase
        end else begin
            top_nxt_s = top_r;
        end
`ifdef FPU_STACK_ENVLOAD_EN
        // Environment load replaces TOP and tags wholesale and suppresses the command.
        if (env_load) begin
            top_nxt_s = env_top;
            for (int p = 0; p < DEPTH; p++) begin
                tag_nxt_s[p] = env_tags[2*p +: 2];
            end
            fault_s = 1'b0;
            c1_s    = 1'b0;
        end else begin
            top_nxt_s = top_nxt_s;
        end
`endif
    end

    // Flatten physical tags for the status word.
    always_comb begin
        tag_word = {(2*DEPTH){1'b0}};
        for (int p = 0; p < DEPTH; p++) begin
            tag_word[2*p +: 2] = tag_r[p];
        end
    end

    // State, read-port and sticky fault registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < DEPTH; p++) begin
                data_r[p] <= {WIDTH{1'b0}};
                tag_r[p]  <= TAG_EMPTY;
            end
            top_r       <= {PTR_W{1'b0}};
            rd_data_a   <= {WIDTH{1'b0}};
            rd_data_b   <= {WIDTH{1'b0}};
            rd_tag_a    <= TAG_EMPTY;
            rd_tag_b    <= TAG_EMPTY;
            stack_fault <= 1'b0;
            fault_c1    <= 1'b0;
        end else begin
            data_r    <= data_nxt_s;
            tag_r     <= tag_nxt_s;
            top_r     <= top_nxt_s;
            rd_data_a <= data_r[rd_phys_a_s];
            rd_data_b <= data_r[rd_phys_b_s];
            rd_tag_a  <= tag_r[rd_phys_a_s];
            rd_tag_b  <= tag_r[rd_phys_b_s];
            if (fault_s) begin
                stack_fault <= 1'b1;
                fault_c1    <= c1_s;
            end else if (clr_fault) begin
                stack_fault <= 1'b0;
                fault_c1    <= 1'b0;
            end else begin
                stack_fault <= stack_fault;
                fault_c1    <= fault_c1;
            end
        end
    end

endmodule

// File: tb/tb_fpu_stack_regfile.sv
// Scoreboard bench for fpu_stack_regfile: a spec-level stack model predicts every cycle's outputs.
module tb_fpu_stack_regfile;

    localparam int W  = 80;
    localparam int D  = 8;
    localparam int PW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [2:0]    cmd = 3'd0;
    logic [PW-1:0] cmd_idx = '0;
    logic [W-1:0]  wr_data = '0;
    logic [1:0]    wr_tag = 2'b00;
    logic [PW-1:0] rd_idx_a = '0;
    logic [PW-1:0] rd_idx_b = '0;
    logic          clr_fault = 1'b0;
    logic [W-1:0]  rd_data_a, rd_data_b;
    logic [1:0]    rd_tag_a, rd_tag_b;
    logic [PW-1:0] top;
    logic [2*D-1:0] tag_word;
    logic          stack_fault, fault_c1;
`ifdef FPU_STACK_ENVLOAD_EN
    logic          env_load = 1'b0;
    logic [PW-1:0] env_top = '0;
    logic [2*D-1:0] env_tags = '0;
`endif

    always #5 clk = ~clk;

    fpu_stack_regfile #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_idx(cmd_idx),
        .wr_data(wr_data), .wr_tag(wr_tag), .rd_idx_a(rd_idx_a), .rd_idx_b(rd_idx_b),
`ifdef FPU_STACK_ENVLOAD_EN
        .env_load(env_load), .env_top(env_top), .env_tags(env_tags),
`endif
        .clr_fault(clr_fault), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .rd_tag_a(rd_tag_a), .rd_tag_b(rd_tag_b), .top(top), .tag_word(tag_word),
        .stack_fault(stack_fault), .fault_c1(fault_c1)
    );

    typedef struct packed {
        logic [W-1:0]   rda;
        logic [W-1:0]   rdb;
        logic [1:0]     rta;
        logic [1:0]     rtb;
        logic [PW-1:0]  top;
        logic [2*D-1:0] tw;
        logic           sf;
        logic           c1;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model: plain arrays with modulo arithmetic on an integer TOP.
    logic [W-1:0] m_data [D];
    logic [1:0]   m_tag  [D];
    int           m_top;
    logic         m_sf, m_c1;
    logic [W-1:0] m_rda, m_rdb;
    logic [1:0]   m_rta, m_rtb;

    function automatic int ph(input int i);
        return (m_top + i) % D;
    endfunction

    task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input logic rst, input logic v, input logic [2:0] c, input int i,
                         input logic [W-1:0] d, input logic [1:0] t, input int ra, input int rb,
                         input logic clr);
        int p, b;
        logic flt, c1;
        logic [1:0] st, tt;
        logic [W-1:0] td;
        if (rst) begin
            for (int k = 0; k < D; k++) begin
                m_data[k] = '0;
                m_tag[k]  = 2'b11;
            end
            m_top = 0; m_sf = 1'b0; m_c1 = 1'b0;
            m_rda = '0; m_rdb = '0; m_rta = 2'b11; m_rtb = 2'b11;
        end else begin
            m_rda = m_data[ph(ra)]; m_rta = m_tag[ph(ra)];
            m_rdb = m_data[ph(rb)]; m_rtb = m_tag[ph(rb)];
            flt = 1'b0; c1 = 1'b0;
            st = (t == 2'b11) ? 2'b10 : t;
            if (v) begin
                case (c)
                    3'd1: begin
                        p = (m_top + D - 1) % D;
                        if (m_tag[p] != 2'b11) begin flt = 1'b1; c1 = 1'b1; end
                        else begin m_top = p; m_data[p] = d; m_tag[p] = st; end
                    end
                    3'd2: begin
                        if (m_tag[m_top] == 2'b11) flt = 1'b1;
                        else begin m_tag[m_top] = 2'b11; m_top = (m_top + 1) % D; end
                    end
                    3'd3: begin m_data[ph(i)] = d; m_tag[ph(i)] = st; end
                    3'd4: begin
                        b = ph(i);
                        if (m_tag[m_top] == 2'b11 || m_tag[b] == 2'b11) flt = 1'b1;
                        else begin
                            td = m_data[m_top]; m_data[m_top] = m_data[b]; m_data[b] = td;
                            tt = m_tag[m_top];  m_tag[m_top]  = m_tag[b];  m_tag[b]  = tt;
                        end
                    end
                    3'd5: m_tag[ph(i)] = 2'b11;
                    3'd6: m_top = (m_top + 1) % D;
                    3'd7: m_top = (m_top + D - 1) % D;
                    default: ;
                endcase
            end
            if (flt) begin m_sf = 1'b1; m_c1 = c1; end
            else if (clr) begin m_sf = 1'b0; m_c1 = 1'b0; end
        end
    endtask

    // Drive one cycle of stimulus on the falling edge and queue the predicted response.
    task automatic step(input logic rst, input logic v, input logic [2:0] c, input int i,
                        input logic [W-1:0] d, input logic [1:0] t, input int ra, input int rb,
                        input logic clr);
        exp_t e;
        @(negedge clk);
        reset = rst; cmd_valid = v; cmd = c; cmd_idx = i[PW-1:0];
        wr_data = d; wr_tag = t; rd_idx_a = ra[PW-1:0]; rd_idx_b = rb[PW-1:0]; clr_fault = clr;
        model(rst, v, c, i, d, t, ra, rb, clr);
        e.rda = m_rda; e.rdb = m_rdb; e.rta = m_rta; e.rtb = m_rtb;
        e.top = m_top[PW-1:0]; e.sf = m_sf; e.c1 = m_c1;
        for (int k = 0; k < D; k++) e.tw[2*k +: 2] = m_tag[k];
        q.push_back(e);
    endtask

    task automatic op(input logic [2:0] c, input int i, input logic [W-1:0] d, input logic [1:0] t);
        step(1'b0, 1'b1, c, i, d, t, 0, 0, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: after each active edge, compare DUT outputs with the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (q.size() > 0) begin
                e = q.pop_front();
                cmp("rd_data_a", rd_data_a, e.rda);
                cmp("rd_data_b", rd_data_b, e.rdb);
                cmp("rd_tag_a", W'(rd_tag_a), W'(e.rta));
                cmp("rd_tag_b", W'(rd_tag_b), W'(e.rtb));
                cmp("top", W'(top), W'(e.top));
                cmp("tag_word", W'(tag_word), W'(e.tw));
                cmp("stack_fault", W'(stack_fault), W'(e.sf));
                cmp("fault_c1", W'(fault_c1), W'(e.c1));
            end
        end
    end

    initial begin
        logic [W-1:0] big;
        big = 80'h3FFF8000000000000000;

        // Single push, then read back ST(0).
        step(1'b1, 1'b0, 3'd0, 0, '0, 2'b00, 0, 0, 1'b0);
        settle();
        cmp("reset_top", W'(top), W'(3'd0));
        cmp("reset_tags", W'(tag_word), W'(16'hFFFF));
        cmp("reset_rd_tag", W'(rd_tag_a), W'(2'b11));
        op(3'd1, 0, big, 2'b00);
        settle();
        cmp("push_top", W'(top), W'(3'd7));
        cmp("push_tag_word", W'(tag_word), W'(16'h3FFF));
        op(3'd0, 0, '0, 2'b00);
        settle();
        cmp("push_read", rd_data_a, big);
        cmp("push_read_tag", W'(rd_tag_a), W'(2'b00));

        // Fill to eight entries, then overflow.
        step(1'b1, 1'b0, 3'd0, 0, '0, 2'b00, 0, 0, 1'b0);
        for (int k = 1; k <= 8; k++) op(3'd1, 0, W'(k), 2'b00);
        settle();
        cmp("full_top", W'(top), W'(3'd0));
        op(3'd1, 0, W'(9), 2'b00);
        settle();
        cmp("ovf_fault", W'(stack_fault), W'(1'b1));
        cmp("ovf_c1", W'(fault_c1), W'(1'b1));
        cmp("ovf_top", W'(top), W'(3'd0));
        op(3'd0, 0, '0, 2'b00);
        settle();
        cmp("ovf_st0", rd_data_a, W'(8));

        // Underflow on empty stack, then clear.
        step(1'b1, 1'b0, 3'd0, 0, '0, 2'b00, 0, 0, 1'b0);
        op(3'd2, 0, '0, 2'b00);
        settle();
        cmp("unf_fault", W'(stack_fault), W'(1'b1));
        cmp("unf_c1", W'(fault_c1), W'(1'b0));
        cmp("unf_top", W'(top), W'(3'd0));
        step(1'b0, 1'b0, 3'd0, 0, '0, 2'b00, 0, 0, 1'b1);
        settle();
        cmp("clr_fault", W'(stack_fault), W'(1'b0));

        // Exchange: ST(0)=5 (tag 00), ST(1)=7, ST(2)=9 (tag 10).
        step(1'b1, 1'b0, 3'd0, 0, '0, 2'b00, 0, 0, 1'b0);
        op(3'd1, 0, W'(9), 2'b10);
        op(3'd1, 0, W'(7), 2'b00);
        op(3'd1, 0, W'(5), 2'b00);
        op(3'd4, 2, '0, 2'b00);
        step(1'b0, 1'b0, 3'd0, 0, '0, 2'b00, 0, 2, 1'b0);
        settle();
        cmp("xchg_st0", rd_data_a, W'(9));
        cmp("xchg_st2", rd_data_b, W'(5));
        cmp("xchg_tag0", W'(rd_tag_a), W'(2'b10));
        cmp("xchg_tag2", W'(rd_tag_b), W'(2'b00));
        op(3'd4, 3, '0, 2'b00);
        settle();
        cmp("xchg_empty_fault", W'(stack_fault), W'(1'b1));
        cmp("xchg_empty_c1", W'(fault_c1), W'(1'b0));

        // Write with same-cycle read sees the old value.
        step(1'b0, 1'b1, 3'd3, 0, W'(8'hAA), 2'b00, 0, 0, 1'b0);
        settle();
        cmp("wr_old", rd_data_a, W'(9));
        op(3'd0, 0, '0, 2'b00);
        settle();
        cmp("wr_new", rd_data_a, W'(8'hAA));

        // Pointer wrap with DECSTP / FREE / INCSTP.
        step(1'b1, 1'b0, 3'd0, 0, '0, 2'b00, 0, 0, 1'b0);
        op(3'd7, 0, '0, 2'b00);
        settle();
        cmp("decstp_wrap", W'(top), W'(3'd7));
        op(3'd3, 0, W'(3), 2'b01);
        op(3'd5, 0, '0, 2'b00);
        settle();
        cmp("free_tag7", W'(tag_word), W'(16'hFFFF));
        op(3'd6, 0, '0, 2'b00);
        settle();
        cmp("incstp_wrap", W'(top), W'(3'd0));
        cmp("wrap_nofault", W'(stack_fault), W'(1'b0));

        // Randomized traffic, push-biased so the stack fills and faults regularly.
        for (int n = 0; n < 3000; n++) begin
            logic [2:0] c;
            c = (($urandom % 4) == 0) ? 3'd1 : 3'($urandom_range(0, 7));
            step(($urandom % 150) == 0, ($urandom % 10) != 0, c, $urandom_range(0, D-1),
                 {$urandom, $urandom, $urandom}, 2'($urandom), $urandom_range(0, D-1),
                 $urandom_range(0, D-1), ($urandom % 8) == 0);
        end

        settle();
        @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fpu_stack_regfile.md
Name: fpu_stack_regfile

Overview:
- Parametrised x87-style register stack: DEPTH physical registers of WIDTH bits, addressed relative to a TOP pointer.
- Holds a 2-bit tag per physical register and detects stack overflow and underflow.
- Sits between the FPU microsequencer (commands) and the arithmetic datapath (two registered read ports, one write path).
- All commands complete in a single cycle.

Parameters:
- WIDTH, 80, register data width in bits.
- DEPTH, 8, number of physical registers; must be a power of two, at least 2.
- PTR_W, $clog2(DEPTH), width of TOP and of relative indices (derived; do not override).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command strobe; cmd is ignored when low
- cmd  in  3  operation: 0 NOP, 1 PUSH, 2 POP, 3 WRITE, 4 XCHG, 5 FREE, 6 INCSTP, 7 DECSTP
- cmd_idx  in  PTR_W  relative index i of ST(i) for WRITE/XCHG/FREE
- wr_data  in  WIDTH  data for PUSH/WRITE
- wr_tag  in  2  tag for PUSH/WRITE (00 valid, 01 zero, 10 special; 11 is illegal and is stored as 10)
- rd_idx_a, rd_idx_b  in  PTR_W  relative read indices
- rd_data_a, rd_data_b  out  WIDTH  registered ST(rd_idx) data
- rd_tag_a, rd_tag_b  out  2  registered ST(rd_idx) tag
- top  out  PTR_W  current TOP pointer
- tag_word  out  2*DEPTH  physical tags; register p occupies bits [2p+1:2p]
- stack_fault  out  1  sticky stack fault
- fault_c1  out  1  C1 on the last fault: 1 overflow, 0 underflow
- clr_fault  in  1  clears stack_fault and fault_c1

Behaviour:
- Physical address of ST(i) = (TOP + i) mod DEPTH. All pointer arithmetic wraps modulo DEPTH.
- Reset, applied on the next clk edge:
  - TOP = 0, all tags = 11 (empty), data registers = 0.
  - rd_data_a/b = 0, rd_tag_a/b = 11, stack_fault = 0, fault_c1 = 0.
  - Reset overrides any command presented in the same cycle.
- Read ports:
  - 1-cycle latency. Data and tag are sampled from the state before the same cycle's command takes effect.
  - A read of an empty register returns its data and tag 11 and does not raise a fault.
- PUSH:
  - If tag[TOP-1] != 11: overflow. State is unchanged; stack_fault = 1, fault_c1 = 1.
  - Otherwise: TOP = TOP-1, reg[new TOP] = wr_data, tag = wr_tag.
- POP:
  - If tag[TOP] == 11: underflow. State is unchanged; stack_fault = 1, fault_c1 = 0.
  - Otherwise: tag[TOP] = 11, TOP = TOP+1. Data is retained.
- WRITE: reg[ST(i)] = wr_data, tag = wr_tag. No fault check; used for result writeback, including into an empty register.
- XCHG:
  - If ST(0) or ST(i) is empty: underflow fault, no swap.
  - Otherwise: swap data and tags of ST(0) and ST(i). i = 0 is a legal no-op.
- FREE: tag[ST(i)] = 11. TOP is unchanged.
- INCSTP / DECSTP: TOP = TOP±1. Tags are unchanged; never faults.
- Fault flags:
  - stack_fault stays set until clr_fault.
  - A new fault raised in the same cycle as clr_fault wins: the flag stays 1 and C1 is updated.
  - Faults do not block later commands.
- One command per cycle; no back-pressure. cmd_valid = 0 is equivalent to NOP.

Optional Feature:
- Macro: FPU_STACK_ENVLOAD_EN.
- When defined, adds ports:
  - env_load  in  1
  - env_top  in  PTR_W
  - env_tags  in  2*DEPTH
- env_load high loads TOP and all tags in one cycle (FLDENV/FRSTOR). Data registers are untouched.
- env_load has priority over cmd, which is ignored that cycle.
- When not defined, these ports are absent and TOP/tags change only through cmd.

Test Plan:
- Reset, then PUSH 0x3FFF8000000000000000 with tag 00 → TOP = 7; next cycle rd_idx_a = 0 gives that value with tag 00; tag_word[15:14] = 00, all other tags 11.
- 8 PUSHes of values 1..8, then a 9th PUSH → TOP = 0 after the 8th; the 9th sets stack_fault = 1, fault_c1 = 1, TOP stays 0, ST(0) = 8.
- Reset, then POP → stack_fault = 1, fault_c1 = 0, TOP = 0; then clr_fault → stack_fault = 0.
- Stack holding ST(0) = 5, ST(2) = 9: XCHG i = 2 → ST(0) = 9, ST(2) = 5, tags swapped. XCHG with i = 3 empty → underflow fault, no change.
- Same cycle: WRITE ST(0) = 0xAA while rd_idx_a = 0 → rd_data_a shows the old value; the following read shows 0xAA.
- DECSTP at TOP = 0 → TOP = 7. FREE i = 0 → tag[7] = 11. INCSTP → TOP = 0. Wrap-around confirmed with no fault.
